fetch_sequencer: RTL and testbench

Sequences the instruction memory read port for the core front end.
- Owns the program counter and drives the word-aligned fetch address to the combinational instruction memory.
- Captures {pc, inst} pairs into a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing in-flight entries and reloading the PC.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_sequencer.sv | 121 ++++++++++++
 tb/tb_fetch_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end: the canonical
// fetch-entry layout, the NOP used for faulted fetches, the default reset
// vector and a PC alignment helper.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  // addi x0, x0, 0 -- substituted for instructions fetched out of range.
  localparam logic [FETCH_XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // One buffered fetch result as seen by decode.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
    logic                  fault;
  } fetch_entry_t;

  // Instructions are word aligned; the two low address bits never reach memory.
  function automatic logic [FETCH_XLEN-1:0] align_pc(input logic [FETCH_XLEN-1:0] pc);
    return {pc[FETCH_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for the fetch buffer. Push and pop may happen in
// the same cycle even when full; flush empties the buffer and wins over both.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Pointer, occupancy and storage update; DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the combinational
// instruction memory, buffers {pc, inst} pairs for decode and handles
// redirects by flushing and reloading the PC.
// Optional build macro FETCH_RANGE_CHECK_EN adds out_fault: fetching from a
// PC above the backed memory range yields a faulted NOP and stalls fetch
// until the next redirect or reset.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN         = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int              IMEM_AW      = 12,
  parameter int              FIFO_DEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
`ifdef FETCH_RANGE_CHECK_EN
  ,
  output logic            out_fault
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef FETCH_RANGE_CHECK_EN
  localparam int ENTRY_W = 2 * XLEN + 1;
`else
  localparam int ENTRY_W = 2 * XLEN;
`endif

  if (IMEM_AW < 3 || IMEM_AW >= XLEN) begin : g_bad_imem_aw
    $error("fetch_sequencer: IMEM_AW must lie in [3, XLEN-1]");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_sequencer: FIFO_DEPTH must be a power of two, at least 2");
  end

  logic [XLEN-1:0]    pc;
  logic               stalled;
  logic [XLEN-1:0]    redirect_target;
  logic [XLEN-1:0]    push_inst;
  logic               range_fault;
  logic               deq;
  logic               enq;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;

  if (XLEN == FETCH_XLEN) begin : g_align_pkg
    assign redirect_target = align_pc(redirect_pc);
  end else begin : g_align_generic
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  end

`ifdef FETCH_RANGE_CHECK_EN
  assign range_fault = (pc[XLEN-1:IMEM_AW] != '0);
`else
  assign range_fault = 1'b0;
`endif

  assign push_inst = range_fault ? XLEN'(NOP_INST) : imem_inst;

  // A redirect discards any handshake presented in the same cycle.
  assign deq = !fifo_empty && out_ready && !redirect_valid;
  assign enq = fetch_en && !redirect_valid && !stalled && (!fifo_full || deq);

`ifdef FETCH_RANGE_CHECK_EN
  assign push_data = {pc, push_inst, range_fault};
  assign out_fault = head_data[0];
  assign out_pc    = head_data[ENTRY_W-1 -: XLEN];
  assign out_inst  = head_data[XLEN:1];
`else
  assign push_data = {pc, push_inst};
  assign out_pc    = head_data[ENTRY_W-1 -: XLEN];
  assign out_inst  = head_data[XLEN-1:0];
`endif

  assign out_valid = (fifo_count != '0);
  assign imem_addr = pc;

  // PC and fault-stall state: reset beats redirect, redirect beats fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= {RESET_VECTOR[XLEN-1:2], 2'b00};
      stalled <= 1'b0;
    end else if (redirect_valid) begin
      pc      <= redirect_target;
      stalled <= 1'b0;
    end else if (enq) begin
      pc      <= pc + XLEN'(4);
      stalled <= range_fault;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (enq),
    .pop     (deq),
    .flush   (redirect_valid),
    .wr_data (push_data),
    .rd_data (head_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a queue-level reference model predicts the
// buffered entries; a separate monitor pops and compares on each accepted
// handshake. Directed phases follow the expected scenarios, then random traffic.
module tb_fetch_sequencer;

  localparam int          XLEN    = 32;
  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam int          IMEM_AW = 12;
  localparam int          DEPTH   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef FETCH_RANGE_CHECK_EN
  logic        out_fault;
`endif

  assign imem_inst = imem_addr ^ 32'hA5A5_0000;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .IMEM_AW      (IMEM_AW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef FETCH_RANGE_CHECK_EN
    ,
    .out_fault      (out_fault)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    bit          fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pc = RV;
  bit          m_stall = 1'b0;
  int          checks = 0;
  int          errors = 0;
  event        mon_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: applies one clock edge's worth of the fetch rules to the
  // expected buffer contents. Runs after the monitor has popped any handshake.
  task automatic model_step();
    exp_t e;
    if (reset) begin
      exp_q.delete();
      m_pc    = RV;
      m_stall = 1'b0;
    end else if (redirect_valid) begin
      exp_q.delete();
      m_pc    = redirect_pc & ~32'h3;
      m_stall = 1'b0;
    end else if (fetch_en && !m_stall && exp_q.size() < DEPTH) begin
      e.pc    = m_pc;
      e.inst  = m_pc ^ 32'hA5A5_0000;
      e.fault = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
      if ((m_pc >> IMEM_AW) != 0) begin
        e.fault = 1'b1;
        e.inst  = 32'h0000_0013;
        m_stall = 1'b1;
      end
`endif
      exp_q.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Monitor: per-cycle address/valid/hold checks and scoreboard pops.
  initial begin
    logic        hold_pend;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    exp_t        e;
    hold_pend = 1'b0;
    hold_pc   = 32'h0;
    hold_inst = 32'h0;
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        chk("hold_pc", out_pc, hold_pc);
        chk("hold_inst", out_inst, hold_inst);
      end
      chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      hold_pend = out_valid && !out_ready && !redirect_valid && !reset;
      hold_pc   = out_pc;
      hold_inst = out_inst;
      if (out_valid && out_ready && !redirect_valid && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected actual pc=%h required no entry", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("deq_pc", out_pc, e.pc);
          chk("deq_inst", out_inst, e.inst);
`ifdef FETCH_RANGE_CHECK_EN
          chk("deq_fault", 32'(out_fault), 32'(e.fault));
`endif
          $display("DEQ pc=%h inst=%h", out_pc, out_inst);
        end
      end
      -> mon_done;
    end
  end

  // Drive one cycle's inputs, let monitor and model process the edge, and
  // return 1 time unit after that edge.
  task automatic cycle(input logic fe, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic rst);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset          = rst;
    @(mon_done);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic fe, input logic rdy);
    for (int i = 0; i < n; i++) cycle(fe, rdy, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset state
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_addr", imem_addr, RV);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);

    // Streaming after reset release
    run(1, 1'b1, 1'b1);
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_inst", out_inst, 32'hA5A5_0000);
    for (int k = 1; k < 4; k++) begin
      run(1, 1'b1, 1'b1);
      chk("stream_pc", out_pc, 32'(k * 4));
    end

    // Back-pressure from a fresh reset
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    run(5, 1'b1, 1'b0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_valid", 32'(out_valid), 32'h1);

    // Redirect with two buffered entries and a live handshake
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    chk("rd_valid", 32'(out_valid), 32'h0);
    chk("rd_addr", imem_addr, 32'h100);
    run(1, 1'b1, 1'b1);
    chk("rd_first_pc", out_pc, 32'h100);
    run(3, 1'b1, 1'b1);
    chk("steady_pc", out_pc, 32'h10C);

    // fetch_en low drains the single entry and freezes the PC
    run(1, 1'b0, 1'b1);
    chk("fe_valid", 32'(out_valid), 32'h0);
    chk("fe_addr", imem_addr, 32'h110);
    run(1, 1'b0, 1'b1);
    chk("fe_addr_hold", imem_addr, 32'h110);
    run(1, 1'b1, 1'b1);
    chk("fe_resume_pc", out_pc, 32'h110);

    // Redirect to the top of the address space
    cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run(1, 1'b1, 1'b1);
    chk("top_pc", out_pc, 32'hFFFF_FFFC);
`ifdef FETCH_RANGE_CHECK_EN
    chk("top_fault", 32'(out_fault), 32'h1);
    chk("top_inst", out_inst, 32'h0000_0013);
    run(1, 1'b1, 1'b1);
    chk("top_stall_valid", 32'(out_valid), 32'h0);
    run(2, 1'b1, 1'b1);
    chk("top_stall_valid2", 32'(out_valid), 32'h0);
`else
    chk("top_inst", out_inst, 32'h5A5A_FFFC);
    run(1, 1'b1, 1'b1);
    chk("wrap_pc", out_pc, 32'h0);
    run(2, 1'b1, 1'b1);
`endif

    // Reset together with redirect: reset wins
    cycle(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
    chk("rr_addr", imem_addr, RV);
    chk("rr_valid", 32'(out_valid), 32'h0);
    run(3, 1'b1, 1'b1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        rst;
      logic        rv;
      logic [31:0] rpc;
      rst = ($urandom % 200) == 0;
      rv  = ($urandom % 25) == 0;
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16))
                                  : 32'($urandom % 4096);
      cycle(($urandom % 5) != 0, ($urandom % 3) != 0, rv, rpc, rst);
    end
    run(4, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
